ex_stage_mdu: RTL and testbench

- Parametrised execute stage for the pipelined MIPS core, sitting between ID and MEM.
- Performs single-cycle ALU ops and iterative unsigned multiply/divide into internal HI/LO registers.
- Uses a valid/ready handshake on both sides with a registered output and a flush input.
- Multi-cycle ops stall upstream through `in_ready`.

---
 rtl/ex_stage_mdu_if.sv | 31 +++
 rtl/ex_stage_mdu.sv | 175 +++++++++++++++++
 tb/tb_ex_stage_mdu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_mdu_if.sv
// Execute-stage handshake bundle: upstream op channel, downstream result channel, flush and busy.
// master = pipeline side driving the stage, slave = the execute stage itself.
interface ex_stage_mdu_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            in_wen;
    logic [RA_W-1:0] in_waddr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_wen;
    logic [RA_W-1:0] out_waddr;
    logic            busy;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_wen, in_waddr, out_ready,
        input  in_ready, out_valid, out_result, out_wen, out_waddr, busy
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_wen, in_waddr, out_ready,
        output in_ready, out_valid, out_result, out_wen, out_waddr, busy
    );
endinterface

// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: single-cycle ALU plus iterative unsigned MULTU/DIVU into HI/LO,
// with a registered valid/ready output and a synchronous flush.
module ex_stage_mdu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    ex_stage_mdu_if.slave bus
);
    localparam int unsigned SH_W  = $clog2(XLEN);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_MULT = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12, OP_MFHI = 4'd13, OP_MFLO = 4'd14, OP_PASS = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [XLEN-1:0] r_hi, w_hi_nxt, r_lo, w_lo_nxt;
    logic [XLEN-1:0] r_opd, w_opd_nxt, r_acc, w_acc_nxt, r_q, w_q_nxt;
    logic [RA_W-1:0] r_waddr_lat, w_waddr_lat_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic [XLEN-1:0] r_out_result, w_out_result_nxt;
    logic            r_out_wen, w_out_wen_nxt;
    logic [RA_W-1:0] r_out_waddr, w_out_waddr_nxt;

    logic            w_in_ready, w_accept;
    logic [SH_W-1:0] w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN:0]   w_mul_sum, w_div_sh, w_div_diff;
    logic [XLEN-1:0] w_mul_acc, w_mul_q, w_div_acc, w_div_q;
    logic            w_div_ge;

    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready) && !bus.flush && !reset;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_shamt    = bus.in_a[SH_W-1:0];

    // single-cycle result path
    always_comb begin
        w_alu = '0;
        case (bus.in_op)
            OP_ADD:  w_alu = bus.in_a + bus.in_b;
            OP_SUB:  w_alu = bus.in_a - bus.in_b;
            OP_AND:  w_alu = bus.in_a & bus.in_b;
            OP_OR:   w_alu = bus.in_a | bus.in_b;
            OP_XOR:  w_alu = bus.in_a ^ bus.in_b;
            OP_NOR:  w_alu = ~(bus.in_a | bus.in_b);
            OP_SLT:  w_alu = XLEN'($signed(bus.in_a) < $signed(bus.in_b));
            OP_SLTU: w_alu = XLEN'(bus.in_a < bus.in_b);
            OP_SLL:  w_alu = bus.in_b << w_shamt;
            OP_SRL:  w_alu = bus.in_b >> w_shamt;
            OP_SRA:  w_alu = XLEN'($signed(bus.in_b) >>> w_shamt);
            OP_MFHI: w_alu = r_hi;
            OP_MFLO: w_alu = r_lo;
            OP_PASS: w_alu = bus.in_b;
            default: w_alu = '0;
        endcase
    end

    // one multiply (shift-add) and one restoring-divide step; {acc,q} shift as a pair
    always_comb begin
        w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opd} : {(XLEN+1){1'b0}});
        w_mul_acc  = w_mul_sum[XLEN:1];
        w_mul_q    = {w_mul_sum[0], r_q[XLEN-1:1]};
        w_div_sh   = {r_acc, r_q[XLEN-1]};
        w_div_diff = w_div_sh - {1'b0, r_opd};
        w_div_ge   = !w_div_diff[XLEN];
        w_div_acc  = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
        w_div_q    = {r_q[XLEN-2:0], w_div_ge};
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_hi_nxt         = r_hi;
        w_lo_nxt         = r_lo;
        w_opd_nxt        = r_opd;
        w_acc_nxt        = r_acc;
        w_q_nxt          = r_q;
        w_waddr_lat_nxt  = r_waddr_lat;
        w_out_valid_nxt  = r_out_valid;
        w_out_result_nxt = r_out_result;
        w_out_wen_nxt    = r_out_wen;
        w_out_waddr_nxt  = r_out_waddr;

        if (r_out_valid && bus.out_ready) w_out_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.in_op == OP_MULT || bus.in_op == OP_DIV) begin
                        w_state_nxt     = (bus.in_op == OP_MULT) ? S_MUL : S_DIV;
                        w_cnt_nxt       = CNT_W'(XLEN);
                        w_acc_nxt       = '0;
                        w_opd_nxt       = (bus.in_op == OP_MULT) ? bus.in_a : bus.in_b;
                        w_q_nxt         = (bus.in_op == OP_MULT) ? bus.in_b : bus.in_a;
                        w_waddr_lat_nxt = bus.in_waddr;
                    end else begin
                        w_out_valid_nxt  = 1'b1;
                        w_out_result_nxt = w_alu;
                        w_out_wen_nxt    = bus.in_wen;
                        w_out_waddr_nxt  = bus.in_waddr;
                    end
                end
            end
            S_MUL, S_DIV: begin
                w_acc_nxt = (r_state == S_MUL) ? w_mul_acc : w_div_acc;
                w_q_nxt   = (r_state == S_MUL) ? w_mul_q   : w_div_q;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt      = S_IDLE;
                    w_hi_nxt         = w_acc_nxt;
                    w_lo_nxt         = w_q_nxt;
                    w_out_valid_nxt  = 1'b1;
                    w_out_result_nxt = w_q_nxt;
                    w_out_wen_nxt    = 1'b0;
                    w_out_waddr_nxt  = r_waddr_lat;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // flush beats completion: HI/LO and the output fields stay as they were
        if (bus.flush) begin
            w_state_nxt      = S_IDLE;
            w_hi_nxt         = r_hi;
            w_lo_nxt         = r_lo;
            w_out_valid_nxt  = 1'b0;
            w_out_result_nxt = r_out_result;
            w_out_wen_nxt    = r_out_wen;
            w_out_waddr_nxt  = r_out_waddr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_opd        <= '0;
            r_acc        <= '0;
            r_q          <= '0;
            r_waddr_lat  <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_wen    <= 1'b0;
            r_out_waddr  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hi         <= w_hi_nxt;
            r_lo         <= w_lo_nxt;
            r_opd        <= w_opd_nxt;
            r_acc        <= w_acc_nxt;
            r_q          <= w_q_nxt;
            r_waddr_lat  <= w_waddr_lat_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_result <= w_out_result_nxt;
            r_out_wen    <= w_out_wen_nxt;
            r_out_waddr  <= w_out_waddr_nxt;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_wen    = r_out_wen;
    assign bus.out_waddr  = r_out_waddr;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Scoreboard bench for ex_stage_mdu: directed ops push expected results, a monitor pops on each transfer.
module tb_ex_stage_mdu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ex_stage_mdu_if #(.XLEN(32), .RA_W(5)) bus ();

    ex_stage_mdu #(.XLEN(32), .RA_W(5)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        wen;
        logic [4:0]  wa;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // inputs change at negedge+1, monitor samples at negedge+3, DUT edge at posedge
    always begin
        @(negedge clk);
        #3;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", bus.out_result);
            end else begin
                e = q.pop_front();
                chk("out_result", bus.out_result, e.res);
                chk("out_wen", 32'(bus.out_wen), 32'(e.wen));
                chk("out_waddr", 32'(bus.out_waddr), 32'(e.wa));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wen, input logic [4:0] wa, input logic [31:0] res,
                         input bit push);
        bit ok = 0;
        exp_t x;
        bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_wen = wen; bus.in_waddr = wa;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (bus.in_ready) begin ok = 1; break; end
            tick();
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1 op=%0d", op);
        end else if (push) begin
            x.res = res;
            x.wen = (op == 4'd11 || op == 4'd12) ? 1'b0 : wen;
            x.wa  = wa;
            q.push_back(x);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic count_stall(input string name, input int exp_cycles);
        int n = 0;
        chk({name, "_busy"}, 32'(bus.busy), 32'd1);
        while (!bus.in_ready && n < 200) begin n++; tick(); end
        chk({name, "_stall"}, 32'(n), 32'(exp_cycles));
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.in_op = 0; bus.in_a = 0; bus.in_b = 0;
        bus.in_wen = 0; bus.in_waddr = 0; bus.out_ready = 1;
        repeat (2) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_wen", 32'(bus.out_wen), 0);
        chk("rst_out_waddr", 32'(bus.out_waddr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        reset = 1'b0;
        tick();

        // back-to-back single-cycle ops
        issue(4'd0,  32'h7FFF_FFFF, 32'h1,         1, 5'd3,  32'h8000_0000, 1);
        issue(4'd1,  32'd3,         32'd5,         1, 5'd4,  32'hFFFF_FFFE, 1);
        issue(4'd6,  32'hFFFF_FFFF, 32'd1,         0, 5'd5,  32'd1,         1);
        issue(4'd7,  32'hFFFF_FFFF, 32'd1,         1, 5'd6,  32'd0,         1);
        issue(4'd10, 32'd4,         32'h8000_0000, 1, 5'd7,  32'hF800_0000, 1);
        issue(4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 1, 5'd8,  32'h00F0_1200, 1);
        issue(4'd3,  32'hF000_0001, 32'h0000_0F00, 1, 5'd9,  32'hF000_0F01, 1);
        issue(4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 1, 5'd10, 32'h5555_5555, 1);
        issue(4'd5,  32'h0000_00F0, 32'h0F00_0000, 1, 5'd11, 32'hF0FF_FF0F, 1);
        issue(4'd8,  32'd36,        32'h0000_0003, 1, 5'd12, 32'h0000_0030, 1);
        issue(4'd9,  32'd8,         32'h8000_0000, 1, 5'd13, 32'h0080_0000, 1);
        issue(4'd15, 32'h1234_5678, 32'hCAFE_BABE, 1, 5'd31, 32'hCAFE_BABE, 1);
        drain(2);

        // multiply / divide with HI/LO readback
        issue(4'd11, 32'd7, 32'd6, 1, 5'd2, 32'd42, 1);
        count_stall("multu_small", 32);
        issue(4'd13, 0, 0, 1, 5'd1, 32'd0,  1);
        issue(4'd14, 0, 0, 1, 5'd1, 32'd42, 1);
        issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 5'd9, 32'h0000_0001, 1);
        count_stall("multu_max", 32);
        issue(4'd13, 0, 0, 1, 5'd14, 32'hFFFF_FFFE, 1);
        issue(4'd14, 0, 0, 1, 5'd15, 32'h0000_0001, 1);
        issue(4'd12, 32'd100, 32'd7, 1, 5'd3, 32'd14, 1);
        count_stall("divu", 32);
        issue(4'd13, 0, 0, 1, 5'd16, 32'd2, 1);
        issue(4'd12, 32'd5, 32'd0, 1, 5'd3, 32'hFFFF_FFFF, 1);
        count_stall("divu_zero", 32);
        issue(4'd13, 0, 0, 1, 5'd17, 32'd5, 1);
        drain(2);

        // backpressure: result held for 5 cycles, next op accepted when out_ready rises
        bus.out_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd2, 1, 5'd20, 32'd3, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_result", bus.out_result, 32'd3);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            tick();
        end
        bus.in_op = 4'd4; bus.in_a = 32'hFF; bus.in_b = 32'h0F; bus.in_wen = 1; bus.in_waddr = 5'd21;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_accept", 32'(bus.in_ready), 1);
        if (bus.in_ready) q.push_back('{res: 32'hF0, wen: 1'b1, wa: 5'd21});
        tick();
        bus.in_valid = 1'b0;
        drain(2);

        // flush mid-DIVU: aborted, HI/LO keep 5 / FFFFFFFF
        issue(4'd12, 32'd1000, 32'd3, 1, 5'd4, 32'd0, 0);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 0);
        chk("flush_valid", 32'(bus.out_valid), 0);
        drain(40);
        chk("flush_no_output", 32'(bus.out_valid), 0);
        issue(4'd13, 0, 0, 1, 5'd1, 32'd5,         1);
        issue(4'd14, 0, 0, 1, 5'd1, 32'hFFFF_FFFF, 1);
        drain(2);

        // flush alongside in_valid drops the op
        bus.in_op = 4'd0; bus.in_a = 32'd9; bus.in_b = 32'd9; bus.in_valid = 1'b1; bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 0);
        tick();
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        tick();
        chk("flush_drop", 32'(bus.out_valid), 0);

        // reset mid-MULTU
        issue(4'd11, 32'd3, 32'd3, 1, 5'd8, 32'd0, 0);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("rst_mul_busy", 32'(bus.busy), 0);
        chk("rst_mul_in_ready", 32'(bus.in_ready), 0);
        tick();
        reset = 1'b0;
        tick();

        // reset while a result is held
        bus.out_ready = 1'b0;
        issue(4'd0, 32'd10, 32'd20, 1, 5'd7, 32'd30, 0);
        chk("hold_valid", 32'(bus.out_valid), 1);
        reset = 1'b1;
        #1;
        chk("rst_hold_valid", 32'(bus.out_valid), 0);
        chk("rst_hold_result", bus.out_result, 0);
        chk("rst_hold_wen", 32'(bus.out_wen), 0);
        chk("rst_hold_waddr", 32'(bus.out_waddr), 0);
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        issue(4'd14, 0, 0, 1, 5'd2, 32'd0, 1);
        issue(4'd0, 32'd2, 32'd2, 1, 5'd3, 32'd4, 1);
        drain(4);

        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
